axi_wr_err_responder: RTL and testbench

//   AXI4 write-side terminating responder: the consumer end of the AW/W channels and the producer of B.

---
 rtl/axi_wr_err_responder.sv | 131 +++++++++++++
 tb/tb_axi_wr_err_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_err_responder.sv
// AXI4 write-channel terminating responder: accepts one AW burst, sinks its W beats
// and answers with a single B carrying a fixed error code and the burst's ID/user.
module axi_wr_err_responder #(
  parameter int          ID_WIDTH   = 4,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 64,
  parameter int          USER_WIDTH = 6,
  parameter logic [1:0]  RESP_CODE  = 2'b11
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_en_i,
  input  logic                    slave_aw_valid_i,
  input  logic [ADDR_WIDTH-1:0]   slave_aw_addr_i,
  input  logic [7:0]              slave_aw_len_i,
  input  logic [ID_WIDTH-1:0]     slave_aw_id_i,
  input  logic [USER_WIDTH-1:0]   slave_aw_user_i,
  output logic                    slave_aw_ready_o,
  input  logic                    slave_w_valid_i,
  input  logic [DATA_WIDTH-1:0]   slave_w_data_i,
  input  logic [DATA_WIDTH/8-1:0] slave_w_strb_i,
  input  logic                    slave_w_last_i,
  input  logic [USER_WIDTH-1:0]   slave_w_user_i,
  output logic                    slave_w_ready_o,
  output logic                    slave_b_valid_o,
  output logic [1:0]              slave_b_resp_o,
  output logic [ID_WIDTH-1:0]     slave_b_id_o,
  output logic [USER_WIDTH-1:0]   slave_b_user_o,
  input  logic                    slave_b_ready_i,
  input  logic                    cnt_clr_i,
  output logic [15:0]             err_cnt_o,
  output logic                    wlast_err_o
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high.
  // Ready/valid outputs here depend only on state, never on the partner's valid/ready.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic                  wlast_err_q, wlast_err_d;

  logic aw_hs, w_hs, b_hs, len_hit;

  // Address, data, strobe, W user and test mode are intentionally discarded.
  logic unused_inputs;
  assign unused_inputs = ^{test_en_i, slave_aw_addr_i, slave_w_data_i,
                           slave_w_strb_i, slave_w_user_i};

  assign aw_hs   = slave_aw_valid_i & (state_q == ST_IDLE);
  assign w_hs    = slave_w_valid_i & (state_q == ST_DATA);
  assign b_hs    = slave_b_ready_i & (state_q == ST_RESP);
  assign len_hit = (beat_cnt_q == len_q);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    user_d      = user_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    err_cnt_d   = err_cnt_q;
    wlast_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          id_d       = slave_aw_id_i;
          user_d     = slave_aw_user_i;
          len_d      = slave_aw_len_i;
          beat_cnt_d = 8'd0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Whichever of the length count or WLAST arrives first closes the burst.
          if (len_hit || slave_w_last_i) begin
            state_d     = ST_RESP;
            wlast_err_d = len_hit ^ slave_w_last_i;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          state_d = ST_IDLE;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cnt_clr_i) err_cnt_d = 16'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      user_q      <= '0;
      len_q       <= 8'd0;
      beat_cnt_q  <= 8'd0;
      err_cnt_q   <= 16'd0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      user_q      <= user_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      err_cnt_q   <= err_cnt_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  assign slave_aw_ready_o = (state_q == ST_IDLE);
  assign slave_w_ready_o  = (state_q == ST_DATA);
  assign slave_b_valid_o  = (state_q == ST_RESP);
  assign slave_b_resp_o   = RESP_CODE;
  assign slave_b_id_o     = id_q;
  assign slave_b_user_o   = user_q;
  assign err_cnt_o        = err_cnt_q;
  assign wlast_err_o      = wlast_err_q;

endmodule

// File: tb/tb_axi_wr_err_responder.sv
// Bench for axi_wr_err_responder: per-cycle vector table plus hand-written
// sequences for back-pressure, early W, reset mid-burst and counter saturation.
module tb_axi_wr_err_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        test_en;
  logic        aw_valid;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [3:0]  aw_id;
  logic [5:0]  aw_user;
  logic        aw_ready;
  logic        w_valid;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic [5:0]  w_user;
  logic        w_ready;
  logic        b_valid;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic [5:0]  b_user;
  logic        b_ready;
  logic        cnt_clr;
  logic [15:0] err_cnt;
  logic        wlast_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  axi_wr_err_responder dut (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .slave_aw_valid_i(aw_valid), .slave_aw_addr_i(aw_addr), .slave_aw_len_i(aw_len),
    .slave_aw_id_i(aw_id), .slave_aw_user_i(aw_user), .slave_aw_ready_o(aw_ready),
    .slave_w_valid_i(w_valid), .slave_w_data_i(w_data), .slave_w_strb_i(w_strb),
    .slave_w_last_i(w_last), .slave_w_user_i(w_user), .slave_w_ready_o(w_ready),
    .slave_b_valid_o(b_valid), .slave_b_resp_o(b_resp), .slave_b_id_o(b_id),
    .slave_b_user_o(b_user), .slave_b_ready_i(b_ready),
    .cnt_clr_i(cnt_clr), .err_cnt_o(err_cnt), .wlast_err_o(wlast_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    aw_valid = 1'b0; aw_len = 8'd0; aw_id = 4'd0; aw_user = 6'd0;
    w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0; cnt_clr = 1'b0;
    aw_addr = $urandom; w_data = {$urandom, $urandom}; w_strb = 8'hFF; w_user = 6'd0;
  endtask

  // Driver + scoreboard: full burst with bounded waits on every handshake.
  task automatic do_burst(input logic [3:0] id, input logic [5:0] user,
                          input logic [7:0] len, input logic clr_at_b);
    logic got;
    logic [9:0] e;
    exp_q.push_back({id, user});
    aw_valid = 1'b1; aw_len = len; aw_id = id; aw_user = user;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = aw_ready;
      step();
    end
    if (!got) chk("aw_timeout", 0, 1);
    aw_valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      w_valid = 1'b1; w_last = (k == int'(len));
      w_data = {$urandom, $urandom};
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        got = w_ready;
        step();
      end
      if (!got) chk("w_timeout", 0, 1);
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_ready = 1'b1; cnt_clr = clr_at_b;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (b_valid) begin
        got = 1'b1;
        e = exp_q.pop_front();
        chk("burst_b_id", b_id, e[9:6]);
        chk("burst_b_user", b_user, e[5:0]);
        chk("burst_b_resp", b_resp, 2'b11);
      end
      step();
    end
    if (!got) chk("b_timeout", 0, 1);
    b_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  typedef struct packed {
    logic       aw_valid;
    logic [7:0] aw_len;
    logic [3:0] aw_id;
    logic [5:0] aw_user;
    logic       w_valid;
    logic       w_last;
    logic       b_ready;
    logic       cnt_clr;
    logic       e_aw_ready;
    logic       e_w_ready;
    logic       e_b_valid;
    logic [3:0] e_b_id;
    logic [5:0] e_b_user;
    logic       e_werr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // inputs: awv len id user | wv last | bready clr  ->  awr wr bv bid buser werr cnt
    vecs[0]  = '{1, 0, 5, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 5, 3, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 3, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 3, 0, 1};
    vecs[4]  = '{1, 3, 2, 1, 0, 0, 0, 0, 1, 0, 0, 5, 3, 0, 1};
    vecs[5]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 1, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 2, 1, 0, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 1, 0, 1};
    vecs[9]  = '{1, 1, 7, 4, 0, 0, 0, 0, 1, 0, 0, 2, 1, 0, 2};
    vecs[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 7, 4, 0, 2};
    vecs[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 7, 4, 0, 2};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 7, 4, 1, 2};
    vecs[13] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 7, 4, 0, 3};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7, 4, 0, 3};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 4, 0, 0};

    test_en = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_resp", b_resp, 2'b11);
    chk("rst_b_id", b_id, 0);
    chk("rst_b_user", b_user, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wlast_err", wlast_err, 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    step();

    // Table: inputs held for one cycle, outputs checked mid-cycle.
    for (int i = 0; i < 16; i++) begin
      aw_valid = vecs[i].aw_valid; aw_len = vecs[i].aw_len;
      aw_id = vecs[i].aw_id; aw_user = vecs[i].aw_user;
      w_valid = vecs[i].w_valid; w_last = vecs[i].w_last;
      b_ready = vecs[i].b_ready; cnt_clr = vecs[i].cnt_clr;
      @(negedge clk);
      chk($sformatf("v%0d_aw_ready", i), aw_ready, vecs[i].e_aw_ready);
      chk($sformatf("v%0d_w_ready", i), w_ready, vecs[i].e_w_ready);
      chk($sformatf("v%0d_b_valid", i), b_valid, vecs[i].e_b_valid);
      chk($sformatf("v%0d_b_id", i), b_id, vecs[i].e_b_id);
      chk($sformatf("v%0d_b_user", i), b_user, vecs[i].e_b_user);
      chk($sformatf("v%0d_wlast_err", i), wlast_err, vecs[i].e_werr);
      chk($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].e_cnt);
      chk($sformatf("v%0d_b_resp", i), b_resp, 2'b11);
      step();
    end
    idle_inputs();

    // len=7 burst with gapped W beats and 5 cycles of B back-pressure.
    aw_valid = 1'b1; aw_len = 8'd7; aw_id = 4'd9; aw_user = 6'd42;
    step();
    aw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_valid = 1'b1; w_last = (k == 7);
      @(negedge clk);
      chk("gap_w_ready", w_ready, 1);
      chk("gap_werr", wlast_err, 0);
      step();
      w_valid = 1'b0; w_last = 1'b0;
      if (k != 7) begin
        @(negedge clk);
        chk("gap_idle_w_ready", w_ready, 1);
        step();
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_b_valid", b_valid, 1);
      chk("bp_b_id", b_id, 9);
      chk("bp_b_user", b_user, 42);
      chk("bp_werr", wlast_err, 0);
      chk("bp_err_cnt", err_cnt, 0);
      step();
    end
    b_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_b_valid", b_valid, 1);
    step();
    b_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_b_valid", b_valid, 0);
    chk("bp_after_aw_ready", aw_ready, 1);
    chk("bp_after_err_cnt", err_cnt, 1);
    step();

    // W presented 4 cycles before AW.
    w_valid = 1'b1; w_last = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("early_w_ready", w_ready, 0);
      step();
    end
    aw_valid = 1'b1; aw_len = 8'd3; aw_id = 4'd4; aw_user = 6'd5;
    @(negedge clk);
    chk("early_aw_cycle_w_ready", w_ready, 0);
    chk("early_aw_ready", aw_ready, 1);
    step();
    aw_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_last = (k == 3);
      @(negedge clk);
      chk("early_beat_w_ready", w_ready, 1);
      step();
    end
    w_valid = 1'b0; w_last = 1'b0;
    @(negedge clk);
    chk("early_b_valid", b_valid, 1);
    chk("early_b_id", b_id, 4);
    chk("early_werr", wlast_err, 0);
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    @(negedge clk);
    chk("early_err_cnt", err_cnt, 2);
    step();

    // Reset in the middle of a burst (after 2 of 4 beats).
    aw_valid = 1'b1; aw_len = 8'd3; aw_id = 4'd6; aw_user = 6'd7;
    step();
    aw_valid = 1'b0;
    w_valid = 1'b1;
    step();
    step();
    w_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_b_valid", b_valid, 0);
    chk("mid_rst_aw_ready", aw_ready, 1);
    chk("mid_rst_w_ready", w_ready, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_b_id", b_id, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    step();
    do_burst(4'd3, 6'd9, 8'd0, 1'b0);
    @(negedge clk);
    chk("post_rst_err_cnt", err_cnt, 1);
    step();

    // Counter saturation and clear-over-increment priority.
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.err_cnt_q;
    @(negedge clk);
    chk("preload_err_cnt", err_cnt, 16'hFFFE);
    step();
    do_burst(4'd1, 6'd2, 8'd1, 1'b0);
    @(negedge clk);
    chk("sat_reach_ffff", err_cnt, 16'hFFFF);
    step();
    do_burst(4'd2, 6'd3, 8'd2, 1'b0);
    @(negedge clk);
    chk("sat_hold_ffff", err_cnt, 16'hFFFF);
    step();
    do_burst(4'd15, 6'd63, 8'd0, 1'b1);
    @(negedge clk);
    chk("clr_priority", err_cnt, 0);
    step();
    do_burst(4'd8, 6'd17, 8'd4, 1'b0);
    @(negedge clk);
    chk("after_clr_inc", err_cnt, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
